postp_sequencer: RTL and testbench
==================================

Name: postp_sequencer

Overview:
- Frame-level controller for the post-processing datapath: max-value search, overlap, zero-setting and face localization.
- When the three output maps (23x23, 19x19, 17x17) are filled, it pulses set, holds run until post-processing signals finish, then drains outstanding output-image writes.
- Reports per-frame face count and frame count, and guards each run with a watchdog timeout.
- Sits between the detector core (frame-ready source) and the post-processing top.

Parameters:
- TIMEOUT_CYCLES, 2000000, max cycles allowed in RUN before the error state.
- SETUP_CYCLES, 2, cycles oSet is held high; legal range 1..15.
- FACE_CNT_W, 8, width of the face counter.
- FRAME_CNT_W, 16, width of the frame counter.

Ports:
- iClk  in  1  system clock
- iReset  in  1  asynchronous, active-high reset
- iFrame_ready  in  1  1-cycle pulse: all three output maps complete
- iPostP_Finish  in  1  post-processing done (level or pulse; sampled in RUN only)
- iFace_valid  in  1  1-cycle pulse per localized face (overlap output-ready)
- iWrite_wait_request  in  1  output-image write master stalled
- iAbort  in  1  synchronous abort
- iClear  in  1  clears error state
- oSet  out  1  configuration pulse to post-processing
- oRun  out  1  run enable to post-processing
- oBusy  out  1  high in any state except IDLE
- oFrame_done  out  1  1-cycle pulse at end of a good frame
- oTimeout  out  1  sticky watchdog error flag
- oFace_count  out  FACE_CNT_W  faces in last completed frame
- oFrame_count  out  FRAME_CNT_W  completed-frame counter

Behaviour:
- Reset: all outputs 0, state IDLE, timer 0, internal face accumulator 0. Reset is asynchronous, active-high, and aborts any operation.
- States: IDLE, SETUP, RUN, DRAIN, DONE, ERR.
- IDLE: on iFrame_ready go to SETUP; clear accumulator.
- SETUP: oSet=1 for exactly SETUP_CYCLES cycles, oRun=0, then go to RUN.
- RUN:
  - oRun=1; timer increments from 0.
  - iPostP_Finish=1 goes to DRAIN.
  - Timer == TIMEOUT_CYCLES-1 with no finish goes to ERR.
  - If finish and timeout occur in the same cycle, finish wins.
- DRAIN: oRun=0; stay while iWrite_wait_request=1; minimum 1 cycle; then go to DONE.
- DONE (1 cycle):
  - oFrame_done=1; oFace_count <= accumulator.
  - oFrame_count increments, wrapping at 2^FRAME_CNT_W.
  - Next state IDLE.
- ERR: oTimeout=1 (sticky), oRun=0, oSet=0. iClear goes to IDLE and drops oTimeout the next cycle. Counters are not updated.
- iAbort:
  - From any state, go to IDLE next cycle; oRun and oSet drop registered.
  - No oFrame_done; counters unchanged; oTimeout preserved.
  - iAbort has priority over every other transition.
- iFace_valid:
  - Counted in RUN and DRAIN only; saturates at 2^FACE_CNT_W-1.
  - If it coincides with the DONE transition cycle (last DRAIN cycle), it is included.
- iFrame_ready outside IDLE is ignored (unless the optional feature is enabled).
- All outputs are registered; latency from iFrame_ready to oSet rising is 1 cycle.
- Timer width is ceil(log2(TIMEOUT_CYCLES)); it clears on entry to RUN.

Optional Feature:
- Macro: POSTP_SEQ_PENDING_EN.
- Enabled: a one-deep pending latch captures iFrame_ready arriving while oBusy=1.
  - DONE then goes directly to SETUP, clearing the latch and the accumulator.
  - iAbort and ERR also clear the latch.
  - A second request while pending is dropped.
- Disabled: requests while busy are discarded; no latch logic.

Decomposition:
- Package postp_seq_pkg:
  - state enum (IDLE, SETUP, RUN, DRAIN, DONE, ERR);
  - default width constants FACE_CNT_W and FRAME_CNT_W;
  - timer-width function.
- One sub-module: postp_watchdog.
  - Parameterized TIMEOUT_CYCLES.
  - Inputs: clear and enable.
  - Output: expired pulse.
- FSM and counters stay in postp_sequencer.

Test Plan:
- Normal frame: iFrame_ready pulse; iPostP_Finish 500 cycles after run; 3 iFace_valid pulses; wait_request low -> oSet high 2 cycles, oRun high until finish, oFrame_done 1 cycle, oFace_count=3, oFrame_count=1.
- Drain stall: iWrite_wait_request held 10 cycles after finish -> oFrame_done exactly 11 cycles after finish sampled; 1 face pulse during drain counted.
- Timeout: TIMEOUT_CYCLES=100, no finish -> ERR after 100 RUN cycles, oTimeout=1, oRun=0, counters unchanged; iClear -> IDLE, oTimeout=0.
- Finish on terminal cycle: iPostP_Finish on timer=99 -> DRAIN, oTimeout stays 0.
- Abort mid-RUN: iAbort at cycle 50 of RUN -> IDLE next cycle, no oFrame_done, oFrame_count unchanged; async iReset mid-SETUP -> all outputs 0 immediately.
- Saturation/pending: 300 face pulses with FACE_CNT_W=8 -> oFace_count=255. With POSTP_SEQ_PENDING_EN, iFrame_ready during RUN -> SETUP immediately after DONE; without the macro -> IDLE.

Source files
------------

// File: rtl/postp_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : postp_seq_pkg
//  Description : Shared types, default widths and helper function for the
//                post-processing frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package postp_seq_pkg;

    // Frame-level controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    // Default counter widths used by the sequencer parameters
    localparam int DEFAULT_FACE_CNT_W  = 8;
    localparam int DEFAULT_FRAME_CNT_W = 16;

    // Watchdog timer width: ceil(log2(cycles)), never below one bit
    function automatic int timer_width(input int cycles);
        if (cycles <= 2) begin
            return 1;
        end
        return $clog2(cycles);
    endfunction

endpackage : postp_seq_pkg
`default_nettype wire

// File: rtl/postp_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : postp_watchdog
//  Description : Run-phase watchdog. Counts enabled cycles from zero and
//                flags the cycle in which the count reaches TIMEOUT_CYCLES-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module postp_watchdog
    import postp_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            TW          = timer_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] c_last_tick = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Next timer value: clear wins, then count, holding at the terminal value
    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (enable_i && (timer_q != c_last_tick)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    // Timer register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expired_o = enable_i && !clear_i && (timer_q == c_last_tick);

endmodule : postp_watchdog
`default_nettype wire

// File: rtl/postp_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : postp_sequencer
//  Description : Frame-level controller for the post-processing datapath.
//                Pulses set, holds run until finish, drains output writes,
//                counts faces/frames and guards RUN with a watchdog.
//  Options     : POSTP_SEQ_PENDING_EN - one-deep latch for frame requests
//                arriving while busy (default build: requests dropped).
//  Revision    : 1.0 - initial release
// ============================================================================
module postp_sequencer
    import postp_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int SETUP_CYCLES   = 2,
    parameter int FACE_CNT_W     = DEFAULT_FACE_CNT_W,
    parameter int FRAME_CNT_W    = DEFAULT_FRAME_CNT_W
) (
    input  logic                   iClk,
    input  logic                   iReset,
    input  logic                   iFrame_ready,
    input  logic                   iPostP_Finish,
    input  logic                   iFace_valid,
    input  logic                   iWrite_wait_request,
    input  logic                   iAbort,
    input  logic                   iClear,
    output logic                   oSet,
    output logic                   oRun,
    output logic                   oBusy,
    output logic                   oFrame_done,
    output logic                   oTimeout,
    output logic [FACE_CNT_W-1:0]  oFace_count,
    output logic [FRAME_CNT_W-1:0] oFrame_count
);

    localparam logic [3:0] c_setup_last = 4'(SETUP_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [3:0]             setup_cnt_q, setup_cnt_d;
    logic [FACE_CNT_W-1:0]  acc_q, acc_d;
    logic                   set_q, set_d;
    logic                   run_q, run_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic [FACE_CNT_W-1:0]  face_cnt_q, face_cnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   w_expired;
    logic                   w_start;

    // Entering SETUP from any other state starts a new frame
    assign w_start = (state_d == ST_SETUP) && (state_q != ST_SETUP);

`ifdef POSTP_SEQ_PENDING_EN
    logic pend_q, pend_d;

    // Pending request latch: capture while busy, cleared on start, abort, error
    always_comb begin
        pend_d = pend_q;
        if (iFrame_ready && busy_q) begin
            pend_d = 1'b1;
        end
        if (iAbort || w_start || (state_d == ST_ERR)) begin
            pend_d = 1'b0;
        end
    end

    // Pending latch register
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    logic pend_q;
    assign pend_q = 1'b0;
`endif

    // Watchdog runs only in RUN and restarts from zero on every entry
    postp_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (iClk),
        .rst_i     (iReset),
        .clear_i   (state_q != ST_RUN),
        .enable_i  (state_q == ST_RUN),
        .expired_o (w_expired)
    );

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (iFrame_ready || pend_q)              state_d = ST_SETUP;
            ST_SETUP: if (setup_cnt_q == c_setup_last)         state_d = ST_RUN;
            ST_RUN: begin
                if (iPostP_Finish)                             state_d = ST_DRAIN;
                else if (w_expired)                            state_d = ST_ERR;
            end
            ST_DRAIN: if (!iWrite_wait_request)                state_d = ST_DONE;
            ST_DONE:  state_d = pend_q ? ST_SETUP : ST_IDLE;
            ST_ERR:   if (iClear)                              state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (iAbort) begin
            state_d = ST_IDLE;
        end
    end

    // Counters and registered outputs derived from the next state
    always_comb begin
        setup_cnt_d = (state_q == ST_SETUP) ? setup_cnt_q + 4'd1 : 4'd0;

        acc_d = acc_q;
        if (w_start) begin
            acc_d = '0;
        end else if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) &&
                     iFace_valid && (acc_q != {FACE_CNT_W{1'b1}})) begin
            acc_d = acc_q + FACE_CNT_W'(1);
        end

        set_d  = (state_d == ST_SETUP);
        run_d  = (state_d == ST_RUN);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);

        timeout_d = timeout_q;
        if (state_d == ST_ERR) begin
            timeout_d = 1'b1;
        end else if ((state_q == ST_ERR) && iClear && !iAbort) begin
            timeout_d = 1'b0;
        end

        face_cnt_d  = face_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (state_d == ST_DONE) begin
            face_cnt_d  = acc_d;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    // State, counter and output registers
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            setup_cnt_q <= 4'd0;
            acc_q       <= '0;
            set_q       <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            face_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            acc_q       <= acc_d;
            set_q       <= set_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            face_cnt_q  <= face_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign oSet         = set_q;
    assign oRun         = run_q;
    assign oBusy        = busy_q;
    assign oFrame_done  = done_q;
    assign oTimeout     = timeout_q;
    assign oFace_count  = face_cnt_q;
    assign oFrame_count = frame_cnt_q;

endmodule : postp_sequencer
`default_nettype wire

// File: tb/tb_postp_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_postp_sequencer
//  Description : Self-checking bench for postp_sequencer (short watchdog).
//                Expectations follow POSTP_SEQ_PENDING_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_postp_sequencer;

    localparam int TIMEOUT = 100;
    localparam int FW      = 8;
    localparam int FRW     = 16;

    logic           iClk = 1'b0;
    logic           iReset, iFrame_ready, iPostP_Finish, iFace_valid;
    logic           iWrite_wait_request, iAbort, iClear;
    logic           oSet, oRun, oBusy, oFrame_done, oTimeout;
    logic [FW-1:0]  oFace_count;
    logic [FRW-1:0] oFrame_count;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_set, n_run, n_done, done_cyc, fin_cyc;
    int exp_frames = 0;
    int exp_face   = 0;

    typedef struct {
        int run_len;
        int faces_run;
        int drain_len;
        int faces_drain;
        int exp_faces;
        int exp_delay;
    } vec_t;

    vec_t vecs[5];

    postp_sequencer #(
        .TIMEOUT_CYCLES (TIMEOUT),
        .SETUP_CYCLES   (2),
        .FACE_CNT_W     (FW),
        .FRAME_CNT_W    (FRW)
    ) dut (
        .iClk                (iClk),
        .iReset              (iReset),
        .iFrame_ready        (iFrame_ready),
        .iPostP_Finish       (iPostP_Finish),
        .iFace_valid         (iFace_valid),
        .iWrite_wait_request (iWrite_wait_request),
        .iAbort              (iAbort),
        .iClear              (iClear),
        .oSet                (oSet),
        .oRun                (oRun),
        .oBusy               (oBusy),
        .oFrame_done         (oFrame_done),
        .oTimeout            (oTimeout),
        .oFace_count         (oFace_count),
        .oFrame_count        (oFrame_count)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and log the output activity seen there
    task automatic tick();
        @(negedge iClk);
        cyc++;
        if (oSet)        n_set++;
        if (oRun)        n_run++;
        if (oFrame_done) begin
            n_done++;
            if (done_cyc < 0) done_cyc = cyc;
        end
    endtask

    // One frame: start, RUN for run_len cycles (finish on the last one if
    // requested), then drain with drain_len stalled cycles plus the final one
    task automatic do_frame(input int run_len, input bit finish, input int faces_run,
                            input int drain_len, input int faces_drain, input bit pend_req);
        int guard;
        n_set = 0; n_run = 0; n_done = 0; done_cyc = -1;
        iFrame_ready = 1'b1;
        tick();
        iFrame_ready = 1'b0;
        guard = 0;
        while (!oRun && guard < 20) begin
            tick();
            guard++;
        end
        check("run_start_bound", guard < 20, 1);
        for (int i = 0; i < run_len; i++) begin
            iPostP_Finish = finish && (i == run_len - 1);
            iFace_valid   = (i < faces_run);
            iFrame_ready  = pend_req && (i == 1);
            tick();
        end
        iPostP_Finish = 1'b0;
        iFace_valid   = 1'b0;
        iFrame_ready  = 1'b0;
        fin_cyc = cyc;
        if (finish) begin
            for (int j = 0; j <= drain_len; j++) begin
                iWrite_wait_request = (j < drain_len);
                iFace_valid         = (j < faces_drain);
                tick();
            end
            iWrite_wait_request = 1'b0;
            iFace_valid         = 1'b0;
        end
    endtask

    // Checks common to every good frame, ending back in IDLE
    task automatic check_good(input string tag, input int run_len, input int faces,
                              input int delay);
        exp_frames = (exp_frames + 1) % (1 << FRW);
        exp_face   = faces;
        check({tag, "_set_cycles"}, n_set, 2);
        check({tag, "_run_cycles"}, n_run, run_len);
        check({tag, "_done_delay"}, done_cyc - fin_cyc, delay);
        check({tag, "_face_count"}, oFace_count, exp_face);
        check({tag, "_frame_count"}, oFrame_count, exp_frames);
        check({tag, "_no_timeout"}, oTimeout, 0);
        tick();
        check({tag, "_done_pulses"}, n_done, 1);
        check({tag, "_idle_after"}, oBusy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit: got 1 expected 0");
        $fatal(1, "time limit");
    end

    initial begin
        int rl, fr, dl, fd, tot;

        vecs[0] = '{run_len: 50,  faces_run: 3,  drain_len: 0,  faces_drain: 0, exp_faces: 3,  exp_delay: 1};
        vecs[1] = '{run_len: 20,  faces_run: 0,  drain_len: 10, faces_drain: 1, exp_faces: 1,  exp_delay: 11};
        vecs[2] = '{run_len: 100, faces_run: 5,  drain_len: 0,  faces_drain: 1, exp_faces: 6,  exp_delay: 1};
        vecs[3] = '{run_len: 1,   faces_run: 0,  drain_len: 0,  faces_drain: 0, exp_faces: 0,  exp_delay: 1};
        vecs[4] = '{run_len: 30,  faces_run: 10, drain_len: 3,  faces_drain: 4, exp_faces: 14, exp_delay: 4};

        iReset = 1'b1; iFrame_ready = 1'b0; iPostP_Finish = 1'b0; iFace_valid = 1'b0;
        iWrite_wait_request = 1'b0; iAbort = 1'b0; iClear = 1'b0;
        repeat (3) tick();
        check("rst_set", oSet, 0);
        check("rst_run", oRun, 0);
        check("rst_busy", oBusy, 0);
        check("rst_done", oFrame_done, 0);
        check("rst_timeout", oTimeout, 0);
        check("rst_faces", oFace_count, 0);
        check("rst_frames", oFrame_count, 0);
        iReset = 1'b0;
        tick();

        // Table-driven good frames
        for (int v = 0; v < 5; v++) begin
            do_frame(vecs[v].run_len, 1'b1, vecs[v].faces_run,
                     vecs[v].drain_len, vecs[v].faces_drain, 1'b0);
            check_good($sformatf("vec%0d", v), vecs[v].run_len,
                       vecs[v].exp_faces, vecs[v].exp_delay);
        end

        // Watchdog timeout, sticky error, clear
        do_frame(TIMEOUT, 1'b0, 2, 0, 0, 1'b0);
        check("to_flag", oTimeout, 1);
        check("to_run_low", oRun, 0);
        check("to_busy", oBusy, 1);
        check("to_run_cycles", n_run, TIMEOUT);
        check("to_frames_kept", oFrame_count, exp_frames);
        check("to_faces_kept", oFace_count, exp_face);
        repeat (4) tick();
        check("to_sticky", oTimeout, 1);
        check("to_no_done", n_done, 0);
        iClear = 1'b1;
        tick();
        iClear = 1'b0;
        check("clr_timeout", oTimeout, 0);
        check("clr_idle", oBusy, 0);

        // Abort after 51 RUN cycles
        do_frame(51, 1'b0, 3, 0, 0, 1'b0);
        check("ab_still_run", oRun, 1);
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        check("ab_run_low", oRun, 0);
        check("ab_idle", oBusy, 0);
        repeat (5) tick();
        check("ab_no_done", n_done, 0);
        check("ab_frames_kept", oFrame_count, exp_frames);
        check("ab_faces_kept", oFace_count, exp_face);

        // Face counter saturation: 5 in RUN + 296 in DRAIN
        do_frame(10, 1'b1, 5, 300, 296, 1'b0);
        check_good("sat", 10, 255, 301);

        // Frame request while busy
        do_frame(10, 1'b1, 0, 0, 0, 1'b1);
        exp_frames = (exp_frames + 1) % (1 << FRW);
        check("pend_frame_count", oFrame_count, exp_frames);
        check("pend_done", oFrame_done, 1);
        tick();
`ifdef POSTP_SEQ_PENDING_EN
        check("pend_set_after_done", oSet, 1);
        check("pend_busy_after_done", oBusy, 1);
`else
        check("pend_set_after_done", oSet, 0);
        check("pend_busy_after_done", oBusy, 0);
`endif
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        tick();
        check("pend_idle_after_abort", oBusy, 0);
        exp_face = 0;

        // Randomised frames against a transaction-level model
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_frame(TIMEOUT, 1'b0, 0, 0, 0, 1'b0);
                check("rnd_timeout", oTimeout, 1);
                check("rnd_to_frames", oFrame_count, exp_frames);
                iClear = 1'b1;
                tick();
                iClear = 1'b0;
                check("rnd_to_clear", oTimeout, 0);
            end else begin
                rl  = $urandom_range(1, TIMEOUT);
                fr  = $urandom_range(0, rl - 1);
                dl  = $urandom_range(0, 20);
                fd  = $urandom_range(0, dl + 1);
                tot = fr + fd;
                if (tot > 255) tot = 255;
                do_frame(rl, 1'b1, fr, dl, fd, 1'b0);
                check_good($sformatf("rnd%0d", r), rl, tot, dl + 1);
            end
        end

        // Asynchronous reset in the middle of SETUP
        iFrame_ready = 1'b1;
        tick();
        iFrame_ready = 1'b0;
        check("ar_in_setup", oSet, 1);
        #2 iReset = 1'b1;
        #1;
        check("ar_set", oSet, 0);
        check("ar_busy", oBusy, 0);
        check("ar_frames", oFrame_count, 0);
        check("ar_faces", oFace_count, 0);
        tick();
        iReset = 1'b0;
        repeat (4) tick();
        check("ar_stays_idle", oBusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_postp_sequencer
`default_nettype wire
